// File: rtl/cmul_share_arb.sv
// cmul_share_arb: round-robin scheduler sharing one pipelined complex
// multiplier among NREQ requesters, with ID-tagged in-order responses.
// Optional build macro CMUL_ARB_PRIO0_EN gives requester 0 absolute
// priority; round-robin then rotates only among requesters 1..NREQ-1.
// The tag pipeline assumes the multiplier registers its operands and
// presents the product LAT cycles after that, so a handshake at edge k
// produces rsp_valid in the cycle after edge k+LAT+2.
module cmul_share_arb #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 32,
  parameter int BWIDTH = 32,
  parameter int LAT    = 1,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int PW    = AWIDTH + BWIDTH + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AWIDTH-1:0]   req_ar,
  input  logic [NREQ*AWIDTH-1:0]   req_ai,
  input  logic [NREQ*BWIDTH-1:0]   req_br,
  input  logic [NREQ*BWIDTH-1:0]   req_bi,
  output logic [AWIDTH-1:0]        mul_ar,
  output logic [AWIDTH-1:0]        mul_ai,
  output logic [BWIDTH-1:0]        mul_br,
  output logic [BWIDTH-1:0]        mul_bi,
  input  logic [PW-1:0]            mul_pr,
  input  logic [PW-1:0]            mul_pi,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [PW-1:0]            rsp_pr,
  output logic [PW-1:0]            rsp_pi,
  output logic                     busy
);

  // In-flight counter must cover the full handshake-to-response window.
  localparam int CW = $clog2(LAT + 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   gnt_any;
  logic [IDW-1:0]         gnt_id;
  logic                   hs;

  logic [AWIDTH-1:0]      mul_ar_q, mul_ai_q;
  logic [BWIDTH-1:0]      mul_br_q, mul_bi_q;
  logic                   iss_vld_q;
  logic [IDW-1:0]         iss_id_q;
  logic [LAT:0]           tag_vld_q;
  logic [LAT:0][IDW-1:0]  tag_id_q;
  logic                   rsp_valid_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [PW-1:0]          rsp_pr_q, rsp_pi_q;

`ifdef CMUL_ARB_PRIO0_EN
  // Candidate at offset off among requesters 1..NREQ-1, starting at base
  // (a base of 0 is treated as 1 since requester 0 is outside the ring).
  function automatic logic [IDW-1:0] ring_idx(input logic [IDW-1:0] base, input int off);
    int b;
    b = (base == '0) ? 1 : int'(base);
    return IDW'(1 + ((b - 1 + off) % (NREQ - 1)));
  endfunction
`else
  // Candidate at offset off from base, wrapping over all requesters.
  function automatic logic [IDW-1:0] ring_idx(input logic [IDW-1:0] base, input int off);
    return IDW'((int'(base) + off) % NREQ);
  endfunction
`endif

  // Combinational grant: first valid requester at or after the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (state_q == S_RUN) begin
`ifdef CMUL_ARB_PRIO0_EN
      if (req_valid[0]) begin
        gnt_any = 1'b1;
      end else begin
        for (int j = 0; j < NREQ - 1; j++) begin
          if (!gnt_any && req_valid[ring_idx(rr_ptr_q, j)]) begin
            gnt_any = 1'b1;
            gnt_id  = ring_idx(rr_ptr_q, j);
          end
        end
      end
`else
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any && req_valid[ring_idx(rr_ptr_q, j)]) begin
          gnt_any = 1'b1;
          gnt_id  = ring_idx(rr_ptr_q, j);
        end
      end
`endif
    end
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  // A grant only ever goes to a valid requester, so it is the handshake.
  assign hs = gnt_any;

  // Pointer advance, in-flight accounting and FSM next state.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q + CW'(hs) - CW'(rsp_valid_q);
    state_d  = state_q;
    if (hs) begin
`ifdef CMUL_ARB_PRIO0_EN
      if (gnt_id != '0)
        rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? IDW'(1) : gnt_id + 1'b1;
`else
      rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
    end
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = (cnt_d != '0) ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (enable)             state_d = S_RUN;
        else if (cnt_d == '0)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, pointer, counter and the ID tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      iss_vld_q   <= 1'b0;
      iss_id_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      // issue stage: aligned with the operands on mul_*
      iss_vld_q   <= hs;
      iss_id_q    <= gnt_id;
      // tag stages: last stage aligned with a valid product
      tag_vld_q   <= {tag_vld_q[LAT-1:0], iss_vld_q};
      tag_id_q    <= {tag_id_q[LAT-1:0], iss_id_q};
      // response stage
      rsp_valid_q <= tag_vld_q[LAT];
    end
  end

  // Datapath: operand capture on handshake, product capture on tag valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ar_q <= '0;
      mul_ai_q <= '0;
      mul_br_q <= '0;
      mul_bi_q <= '0;
      rsp_id_q <= '0;
      rsp_pr_q <= '0;
      rsp_pi_q <= '0;
    end else begin
      if (hs) begin
        mul_ar_q <= req_ar[gnt_id*AWIDTH +: AWIDTH];
        mul_ai_q <= req_ai[gnt_id*AWIDTH +: AWIDTH];
        mul_br_q <= req_br[gnt_id*BWIDTH +: BWIDTH];
        mul_bi_q <= req_bi[gnt_id*BWIDTH +: BWIDTH];
      end
      if (tag_vld_q[LAT]) begin
        rsp_id_q <= tag_id_q[LAT];
        rsp_pr_q <= mul_pr;
        rsp_pi_q <= mul_pi;
      end
    end
  end

  assign mul_ar    = mul_ar_q;
  assign mul_ai    = mul_ai_q;
  assign mul_br    = mul_br_q;
  assign mul_bi    = mul_bi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_pr    = rsp_pr_q;
  assign rsp_pi    = rsp_pi_q;
  assign busy      = (state_q == S_RUN) || (cnt_q != '0);

endmodule

// File: tb/tb_cmul_share_arb.sv
// Bench for cmul_share_arb: pipelined multiplier model plus a queue-based
// reference of grants and ID-tagged responses.
module tb_cmul_share_arb;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int BW   = 32;
  localparam int LAT  = 1;
  localparam int IDW  = 2;
  localparam int PW   = AW + BW + 2;

  logic                 clk, rst_n, enable;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*AW-1:0]   req_ar, req_ai;
  logic [NREQ*BW-1:0]   req_br, req_bi;
  logic [AW-1:0]        mul_ar, mul_ai;
  logic [BW-1:0]        mul_br, mul_bi;
  logic [PW-1:0]        mul_pr, mul_pi;
  logic                 rsp_valid, busy;
  logic [IDW-1:0]       rsp_id;
  logic [PW-1:0]        rsp_pr, rsp_pi;

  cmul_share_arb #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
    .mul_ar(mul_ar), .mul_ai(mul_ai), .mul_br(mul_br), .mul_bi(mul_bi),
    .mul_pr(mul_pr), .mul_pi(mul_pi),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pr(rsp_pr), .rsp_pi(rsp_pi),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [PW-1:0] c_re(input logic signed [AW-1:0] ar, ai,
                                                input logic signed [BW-1:0] br, bi);
    logic signed [PW-1:0] a1, a2, b1, b2;
    a1 = ar; a2 = ai; b1 = br; b2 = bi;
    return a1 * b1 - a2 * b2;
  endfunction

  function automatic logic signed [PW-1:0] c_im(input logic signed [AW-1:0] ar, ai,
                                                input logic signed [BW-1:0] br, bi);
    logic signed [PW-1:0] a1, a2, b1, b2;
    a1 = ar; a2 = ai; b1 = br; b2 = bi;
    return a1 * b2 + a2 * b1;
  endfunction

  // Shared multiplier: registers operands, product appears LAT cycles later.
  logic signed [PW-1:0] mpr_q [0:LAT];
  logic signed [PW-1:0] mpi_q [0:LAT];
  always @(posedge clk) begin
    mpr_q[0] <= c_re($signed(mul_ar), $signed(mul_ai), $signed(mul_br), $signed(mul_bi));
    mpi_q[0] <= c_im($signed(mul_ar), $signed(mul_ai), $signed(mul_br), $signed(mul_bi));
    for (int i = 1; i <= LAT; i++) begin
      mpr_q[i] <= mpr_q[i-1];
      mpi_q[i] <= mpi_q[i-1];
    end
  end
  assign mul_pr = mpr_q[LAT];
  assign mul_pi = mpi_q[LAT];

  typedef struct {
    int                   id;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    int                   due;
  } exp_t;

  exp_t q[$];
  int   rsp_log_id[$];
  int   rsp_log_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ptr = 0;
  bit   granting = 0;
  int   last_gnt = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference arbitration: scan upward from the pointer with wrap-around.
  function automatic int ref_grant(input logic [NREQ-1:0] v, input int p);
`ifdef CMUL_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int off = 0; off < NREQ; off++) begin
      int c;
      c = (p + off) % NREQ;
      if (c != 0 && v[c]) return c;
    end
    return -1;
`else
    for (int off = 0; off < NREQ; off++) begin
      int c;
      c = (p + off) % NREQ;
      if (v[c]) return c;
    end
    return -1;
`endif
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_ar[i*AW +: AW] = AW'($urandom);
      req_ai[i*AW +: AW] = AW'($urandom);
      req_br[i*BW +: BW] = BW'($urandom);
      req_bi[i*BW +: BW] = BW'($urandom);
    end
  endtask

  // One clock: check grant, predict, advance, check response and busy.
  task automatic cycle();
    int   eg;
    logic [NREQ-1:0] er;
    bit   en_s, rsp_now;
    exp_t e;
    #2;
    eg = granting ? ref_grant(req_valid, ptr) : -1;
    er = (eg >= 0) ? (NREQ'(1) << eg) : '0;
    chk("req_ready", req_ready, er);
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) last_gnt = i;
    if (eg >= 0) begin
      e.id  = eg;
      e.pr  = c_re($signed(req_ar[eg*AW +: AW]), $signed(req_ai[eg*AW +: AW]),
                   $signed(req_br[eg*BW +: BW]), $signed(req_bi[eg*BW +: BW]));
      e.pi  = c_im($signed(req_ar[eg*AW +: AW]), $signed(req_ai[eg*AW +: AW]),
                   $signed(req_br[eg*BW +: BW]), $signed(req_bi[eg*BW +: BW]));
      e.due = cyc + 1 + LAT + 2;
      q.push_back(e);
`ifdef CMUL_ARB_PRIO0_EN
      if (eg != 0) ptr = (eg + 1) % NREQ;
`else
      ptr = (eg + 1) % NREQ;
`endif
    end
    en_s = enable;
    @(posedge clk);
    cyc++;
    granting = en_s;
    #1;
    rsp_now = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      rsp_now = 1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_pr", rsp_pr, $unsigned(e.pr));
      chk("rsp_pi", rsp_pi, $unsigned(e.pi));
      rsp_log_id.push_back(int'(rsp_id));
      rsp_log_cyc.push_back(cyc);
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
    end
    chk("busy", busy, (granting || q.size() > 0 || rsp_now) ? 1 : 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid_now", rsp_valid, 0);
    q.delete();
    granting = 0;
    ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_pr", rsp_pr, 0);
    chk("rst_rsp_pi", rsp_pi, 0);
    chk("rst_mul_ops", {mul_ar, mul_ai, mul_br, mul_bi}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic signed [PW-1:0] two63;
    two63 = '0;
    two63[63] = 1'b1;
    rst_n = 1'b0; enable = 1'b1; req_valid = '1;
    req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0;
    #3;
    apply_reset();

    // single request from requester 2
    enable = 1'b1; req_valid = '0;
    cycle();
    req_ar[2*AW +: AW] = AW'(3);  req_ai[2*AW +: AW] = AW'(4);
    req_br[2*BW +: BW] = BW'(5);  req_bi[2*BW +: BW] = BW'(-2);
    req_valid = 4'b0100;
    cycle();
    chk("t1_grant", last_gnt, 2);
    req_valid = '0;
    repeat (2) cycle();
    cycle();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_rsp_pr", rsp_pr, 23);
    chk("t1_rsp_pi", rsp_pi, 14);
    cycle();

    // all requesters valid for 8 cycles
    enable = 1'b0;
    apply_reset();
    enable = 1'b1; req_valid = '0;
    cycle();
    rsp_log_id.delete(); rsp_log_cyc.delete();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cycle();
      chk("t2_grant", last_gnt, i % NREQ);
    end
    req_valid = '0;
    repeat (4) cycle();
    chk("t2_rsp_count", rsp_log_id.size(), 8);
    for (int i = 0; i < rsp_log_id.size(); i++) begin
      chk("t2_rsp_order", rsp_log_id[i], i % NREQ);
      if (i > 0) chk("t2_rsp_back2back", rsp_log_cyc[i], rsp_log_cyc[i-1] + 1);
    end

    // drain: enable falls on the second of two handshakes
    rsp_log_id.delete(); rsp_log_cyc.delete();
    rand_ops();
    req_valid = 4'b0011;
    cycle();
    enable = 1'b0;
    cycle();
    chk("t3_hs_on_fall", last_gnt >= 0, 1);
    cycle();
    chk("t3_no_grant", req_ready, 0);
    req_valid = '0;
    for (int n = 0; n < 20 && busy; n++) cycle();
    chk("t3_busy_low", busy, 0);
    chk("t3_rsp_count", rsp_log_id.size(), 2);

    // reset with three operations in flight
    enable = 1'b1;
    cycle();
    req_valid = '1;
    repeat (3) begin rand_ops(); cycle(); end
    enable = 1'b0;
    apply_reset();
    req_valid = '0;
    repeat (6) cycle();
    enable = 1'b1; req_valid = '1;
    rand_ops();
    cycle();
    cycle();
    chk("t4_first_grant", last_gnt, 0);

    // signed extremes on requester 1
    req_ar[1*AW +: AW] = 32'h8000_0000; req_ai[1*AW +: AW] = 32'h8000_0000;
    req_br[1*BW +: BW] = 32'h8000_0000; req_bi[1*BW +: BW] = 32'h8000_0000;
    req_valid = 4'b0010;
    cycle();
    chk("t5_grant", last_gnt, 1);
    req_valid = '0;
    repeat (2) cycle();
    cycle();
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_pr", rsp_pr, 0);
    chk("t5_rsp_pi", rsp_pi, $unsigned(two63));

`ifdef CMUL_ARB_PRIO0_EN
    // requester 0 priority over requester 1
    req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      cycle();
      chk("t7_prio_grant", last_gnt, 0);
    end
    req_valid = 4'b0010;
    cycle();
    chk("t7_after_prio", last_gnt, 1);
    req_valid = '0;
`endif

    // randomized traffic with occasional enable toggles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      req_valid = NREQ'($urandom);
      rand_ops();
      cycle();
    end
    enable = 1'b0; req_valid = '0;
    for (int n = 0; n < 20 && (busy || q.size() > 0); n++) cycle();
    chk("t6_drained", q.size(), 0);
    chk("t6_busy_low", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
